img_frame_sender: RTL and testbench

Parametrised frame transmitter. Reads a WIDTH x HEIGHT image from a synchronous-read BRAM and streams it over UART as one framed packet: optional sync header, pixel bytes, and a trailing XOR checksum. Multi-byte pixels, configurable BRAM read latency and optional 2:1 decimation are supported. Sits between the frame-buffer BRAM and the board UART pin, and is started by the image-received pulse.

---
 rtl/img_frame_sender.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_img_frame_sender.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_frame_sender.sv
`default_nettype none
// ============================================================================
// Module   : img_frame_sender
// Purpose  : Reads a WIDTH x HEIGHT image from a synchronous-read BRAM and
//            streams it over a UART line as one framed packet. The packet is
//            an optional 0xA5 0x5A sync header, the pixel bytes (MSB first),
//            and an optional trailing XOR checksum. Supports multi-byte
//            pixels, a configurable BRAM read latency and 2:1 decimation.
//            A small UART transmitter is built into the module.
// Ports    :
//   clk          in   system clock
//   rst_in       in   asynchronous active-low reset
//   start_in     in   one-cycle start pulse, sampled only in IDLE
//   decim_in     in   latched at start; 1 = even rows/columns only
//   abort_in     in   level; end the frame after the byte in flight
//   data_in      in   BRAM read data (PIXEL_BITS)
//   addr_out     out  BRAM read address, row-major
//   tx_out       out  UART serial line
//   busy_out     out  high while a frame is in progress
//   done_out     out  one-cycle pulse when a complete frame finishes
//   byte_out     out  byte currently presented to the UART transmitter
//   byte_stb_out out  one-cycle pulse that starts a UART byte
//   state_out    out  current FSM state (debug)
// Revision : 1.0 - initial release
// ============================================================================
module img_frame_sender #(
  parameter int WIDTH           = 64,
  parameter int HEIGHT          = 64,
  parameter int PIXEL_BITS      = 8,
  parameter int BRAM_LATENCY    = 2,
  parameter int CLOCKS_PER_BAUD = 50,
  parameter int SYNC_EN         = 1,
  parameter int ADDR_W          = $clog2(WIDTH*HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic                  decim_in,
  input  logic                  abort_in,
  input  logic [PIXEL_BITS-1:0] data_in,
  output logic [ADDR_W-1:0]     addr_out,
  output logic                  tx_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [7:0]            byte_out,
  output logic                  byte_stb_out,
  output logic [2:0]            state_out
);

  localparam int c_BYTES = PIXEL_BITS / 8;
  localparam int c_CW    = $clog2(WIDTH + 1);
  localparam int c_RW    = $clog2(HEIGHT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_FETCH = 3'd2,
    S_SEND  = 3'd3,
    S_CHK   = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Frame FSM registers
  // --------------------------------------------------------------------------
  state_t                r_state, w_state_nx;
  logic [1:0]            r_phase, w_phase_nx;   // byte handshake sub-phase
  logic [1:0]            r_idx,   w_idx_nx;     // header / pixel byte index
  logic [2:0]            r_lat,   w_lat_nx;     // BRAM latency counter
  logic [c_RW-1:0]       r_row,   w_row_nx;
  logic [c_CW-1:0]       r_col,   w_col_nx;
  logic                  r_decim, w_decim_nx;
  logic                  r_abort, w_abort_nx;   // sticky abort request
  logic [7:0]            r_chk,   w_chk_nx;
  logic [PIXEL_BITS-1:0] r_pix,   w_pix_nx;
  logic [ADDR_W-1:0]     r_addr,  w_addr_nx;
  logic [7:0]            r_byte,  w_byte_nx;
  logic                  r_stb,   w_stb_nx;

  logic                  w_abort_any;
  logic                  w_hs_issue;
  logic                  w_hs_done;
  logic [7:0]            w_tx_byte;
  logic [7:0]            w_pix_byte;
  logic [c_CW-1:0]       w_col_step;
  logic [c_RW-1:0]       w_row_step;

  // --------------------------------------------------------------------------
  // Built-in UART transmitter (8N1). It has no reset: its all-zero state is
  // idle with the line high, and a stray in-flight byte simply runs out.
  // --------------------------------------------------------------------------
  logic        r_utx_busy;
  logic [9:0]  r_utx_shift;
  logic [15:0] r_utx_baud;
  logic [3:0]  r_utx_bit;
  logic        w_uart_done;

  always_ff @(posedge clk) begin
    if (!r_utx_busy) begin
      if (r_stb) begin
        r_utx_busy  <= 1'b1;
        r_utx_shift <= {1'b1, r_byte, 1'b0};
        r_utx_baud  <= '0;
        r_utx_bit   <= '0;
      end
    end else if (r_utx_baud >= 16'(CLOCKS_PER_BAUD - 1)) begin
      r_utx_baud  <= '0;
      r_utx_shift <= {1'b1, r_utx_shift[9:1]};
      r_utx_bit   <= r_utx_bit + 4'd1;
      // ">=" lets an arbitrary power-up count still terminate
      if (r_utx_bit >= 4'd9) begin
        r_utx_busy <= 1'b0;
      end
    end else begin
      r_utx_baud <= r_utx_baud + 16'd1;
    end
  end

  assign w_uart_done = ~r_utx_busy;
  assign tx_out      = r_utx_busy ? r_utx_shift[0] : 1'b1;

  // --------------------------------------------------------------------------
  // Datapath helpers
  // --------------------------------------------------------------------------
  assign w_abort_any = r_abort | abort_in;
  assign w_pix_byte  = 8'(r_pix >> ((c_BYTES - 1 - int'(r_idx)) * 8));
  assign w_col_step  = r_col + (r_decim ? c_CW'(2) : c_CW'(1));
  assign w_row_step  = r_row + (r_decim ? c_RW'(2) : c_RW'(1));

  always_comb begin
    w_tx_byte = 8'h00;
    case (r_state)
      S_HDR:   w_tx_byte = (r_idx == 2'd0) ? 8'hA5 : 8'h5A;
      S_SEND:  w_tx_byte = w_pix_byte;
      S_CHK:   w_tx_byte = r_chk;
      default: w_tx_byte = 8'h00;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_idx   <= '0;
      r_lat   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_decim <= 1'b0;
      r_abort <= 1'b0;
      r_chk   <= '0;
      r_pix   <= '0;
      r_addr  <= '0;
      r_byte  <= '0;
      r_stb   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_phase <= w_phase_nx;
      r_idx   <= w_idx_nx;
      r_lat   <= w_lat_nx;
      r_row   <= w_row_nx;
      r_col   <= w_col_nx;
      r_decim <= w_decim_nx;
      r_abort <= w_abort_nx;
      r_chk   <= w_chk_nx;
      r_pix   <= w_pix_nx;
      r_addr  <= w_addr_nx;
      r_byte  <= w_byte_nx;
      r_stb   <= w_stb_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_idx_nx   = r_idx;
    w_lat_nx   = r_lat;
    w_row_nx   = r_row;
    w_col_nx   = r_col;
    w_decim_nx = r_decim;
    w_abort_nx = (r_state == S_IDLE) ? 1'b0 : w_abort_any;
    w_chk_nx   = r_chk;
    w_pix_nx   = r_pix;
    w_addr_nx  = r_addr;
    w_byte_nx  = r_byte;
    w_stb_nx   = 1'b0;
    w_hs_issue = 1'b0;
    w_hs_done  = 1'b0;

    // Byte handshake: issue on done high, see it drop, then rise again.
    // An abort is only honoured before a strobe or after the final rise.
    if (r_state == S_HDR || r_state == S_SEND || r_state == S_CHK) begin
      case (r_phase)
        2'd0: begin
          if (w_abort_any) begin
            w_state_nx = S_IDLE;
            w_addr_nx  = '0;
            w_idx_nx   = '0;
          end else if (w_uart_done) begin
            w_hs_issue = 1'b1;
            w_byte_nx  = w_tx_byte;
            w_stb_nx   = 1'b1;
            w_phase_nx = 2'd1;
          end
        end
        2'd1: begin
          if (!w_uart_done) w_phase_nx = 2'd2;
        end
        default: begin
          if (w_uart_done) begin
            w_hs_done  = 1'b1;
            w_phase_nx = 2'd0;
          end
        end
      endcase
    end

    case (r_state)
      S_IDLE: begin
        if (start_in) begin
          w_decim_nx = decim_in;
          w_abort_nx = abort_in;
          w_row_nx   = '0;
          w_col_nx   = '0;
          w_addr_nx  = '0;
          w_chk_nx   = '0;
          w_idx_nx   = '0;
          w_phase_nx = '0;
          w_lat_nx   = '0;
          w_state_nx = (SYNC_EN != 0) ? S_HDR : S_FETCH;
        end
      end

      S_HDR: begin
        if (w_hs_done) begin
          if (w_abort_any) begin
            w_state_nx = S_IDLE;
            w_addr_nx  = '0;
            w_idx_nx   = '0;
          end else if (r_idx == 2'd1) begin
            w_idx_nx   = '0;
            w_state_nx = S_FETCH;
          end else begin
            w_idx_nx = r_idx + 2'd1;
          end
        end
      end

      S_FETCH: begin
        // Address has been stable since entry; data is valid once the
        // counter has covered the full read latency.
        if (r_lat == 3'(BRAM_LATENCY)) begin
          w_lat_nx = '0;
          w_pix_nx = data_in;
          if (w_abort_any) begin
            w_state_nx = S_IDLE;
            w_addr_nx  = '0;
          end else begin
            w_state_nx = S_SEND;
          end
        end else begin
          w_lat_nx = r_lat + 3'd1;
        end
      end

      S_SEND: begin
        if (w_hs_issue) w_chk_nx = r_chk ^ w_tx_byte;
        if (w_hs_done) begin
          if (w_abort_any) begin
            w_state_nx = S_IDLE;
            w_addr_nx  = '0;
            w_idx_nx   = '0;
          end else if (r_idx != 2'(c_BYTES - 1)) begin
            w_idx_nx = r_idx + 2'd1;
          end else begin
            w_idx_nx = '0;
            // WIDTH/HEIGHT are even, so the step lands exactly on the limit
            if (w_col_step == c_CW'(WIDTH)) begin
              w_col_nx = '0;
              if (w_row_step == c_RW'(HEIGHT)) begin
                w_state_nx = (SYNC_EN != 0) ? S_CHK : S_FIN;
              end else begin
                w_row_nx   = w_row_step;
                w_addr_nx  = ADDR_W'(w_row_step) * ADDR_W'(WIDTH);
                w_state_nx = S_FETCH;
              end
            end else begin
              w_col_nx   = w_col_step;
              w_addr_nx  = ADDR_W'(r_row) * ADDR_W'(WIDTH) + ADDR_W'(w_col_step);
              w_state_nx = S_FETCH;
            end
          end
        end
      end

      S_CHK: begin
        if (w_hs_done) begin
          w_state_nx = w_abort_any ? S_IDLE : S_FIN;
          if (w_abort_any) w_addr_nx = '0;
        end
      end

      S_FIN: begin
        w_state_nx = S_IDLE;
        w_addr_nx  = '0;
        w_phase_nx = '0;
        w_idx_nx   = '0;
      end

      default: begin
        w_state_nx = S_IDLE;
        w_addr_nx  = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign addr_out     = r_addr;
  assign busy_out     = (r_state != S_IDLE);
  assign done_out     = (r_state == S_FIN);
  assign byte_out     = r_byte;
  assign byte_stb_out = r_stb;
  assign state_out    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_img_frame_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_img_frame_sender
// Purpose  : Directed self-checking bench for img_frame_sender. Two instances:
//            A = 4x4, 8-bit pixels, latency 2, sync on;
//            B = 4x4, 16-bit pixels, latency 3, sync off.
//            Serial output is decoded from tx_out and compared with
//            hand-derived byte lists.
// Revision : 1.0 - initial release
// ============================================================================
module tb_img_frame_sender;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       start_a = 1'b0, decim_a = 1'b0, abort_a = 1'b0;
  logic [7:0] data_a;
  logic [3:0] addr_a;
  logic       tx_a, busy_a, done_a, stb_a;
  logic [7:0] byte_a;
  logic [2:0] state_a;

  logic        start_b = 1'b0, decim_b = 1'b0, abort_b = 1'b0;
  logic [15:0] data_b;
  logic [3:0]  addr_b;
  logic        tx_b, busy_b, done_b, stb_b;
  logic [7:0]  byte_b;
  logic [2:0]  state_b;

  logic [7:0]  mem_a [0:15];
  logic [15:0] mem_b [0:15];
  logic [7:0]  pa0, pa1;
  logic [15:0] pb0, pb1, pb2;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [3:0] fetch_addr_a[$];
  int         fetch_len_b[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  img_frame_sender #(
    .WIDTH(4), .HEIGHT(4), .PIXEL_BITS(8), .BRAM_LATENCY(2),
    .CLOCKS_PER_BAUD(CPB), .SYNC_EN(1)
  ) dut_a (
    .clk(clk), .rst_in(rst_n), .start_in(start_a), .decim_in(decim_a),
    .abort_in(abort_a), .data_in(data_a), .addr_out(addr_a), .tx_out(tx_a),
    .busy_out(busy_a), .done_out(done_a), .byte_out(byte_a),
    .byte_stb_out(stb_a), .state_out(state_a)
  );

  img_frame_sender #(
    .WIDTH(4), .HEIGHT(4), .PIXEL_BITS(16), .BRAM_LATENCY(3),
    .CLOCKS_PER_BAUD(CPB), .SYNC_EN(0)
  ) dut_b (
    .clk(clk), .rst_in(rst_n), .start_in(start_b), .decim_in(decim_b),
    .abort_in(abort_b), .data_in(data_b), .addr_out(addr_b), .tx_out(tx_b),
    .busy_out(busy_b), .done_out(done_b), .byte_out(byte_b),
    .byte_stb_out(stb_b), .state_out(state_b)
  );

  // BRAM models: a register pipeline of exactly the configured latency
  always @(posedge clk) begin
    pa0 <= mem_a[addr_a];
    pa1 <= pa0;
    pb0 <= mem_b[addr_b];
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign data_a = pa1;
  assign data_b = pb2;

  function automatic logic line_of(input int sel);
    return (sel != 0) ? tx_b : tx_a;
  endfunction

  // UART receiver: sample mid-bit on falling clock edges
  task automatic rx_loop(input int sel);
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (line_of(sel) == 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = line_of(sel);
        end
        repeat (CPB) @(negedge clk);
        if (sel != 0) q_b.push_back(b);
        else          q_a.push_back(b);
      end
    end
  endtask

  initial rx_loop(0);
  initial rx_loop(1);

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic pulse_start_a(input logic d);
    @(negedge clk);
    decim_a = d;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    decim_a = 1'b0;
  endtask

  // Follows a frame until busy falls; records FETCH entry addresses (A)
  // and FETCH dwell lengths (B).
  task automatic run_frame(input int sel, output int n_done, output int tmo);
    logic [2:0] st;
    logic [2:0] pst;
    int cyc;
    int flen;
    n_done = 0;
    tmo    = 0;
    cyc    = 0;
    flen   = 0;
    pst    = 3'd0;
    forever begin
      st = (sel != 0) ? state_b : state_a;
      if (st == 3'd2) begin
        if (pst != 3'd2) begin
          flen = 0;
          if (sel == 0) fetch_addr_a.push_back(addr_a);
        end
        flen++;
      end else if (pst == 3'd2 && sel != 0) begin
        fetch_len_b.push_back(flen);
      end
      if (((sel != 0) ? done_b : done_a) == 1'b1) n_done++;
      pst = st;
      if (((sel != 0) ? busy_b : busy_a) == 1'b0) break;
      if (cyc >= 6000) begin
        tmo = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (addr_a !== 4'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", addr_a); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_a); end
    n_tests++; if (byte_a !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h want 00", byte_a); end
    n_tests++; if (stb_a !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %b want 0", stb_a); end
    n_tests++; if (state_a !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_a); end
    n_tests++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx_a); end
    n_tests++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Full frame with BRAM[a]=a+offset; checksum given by hand
  task automatic test_full_frame(input int offset, input logic [7:0] chk);
    logic [7:0] exp[$];
    int nd, tmo;
    for (int i = 0; i < 16; i++) mem_a[i] = 8'(i + offset);
    exp = {8'hA5, 8'h5A};
    for (int i = 0; i < 16; i++) exp.push_back(8'(i + offset));
    exp.push_back(chk);
    q_a.delete();
    fetch_addr_a.delete();
    pulse_start_a(1'b0);
    n_tests++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL full%0d_busy_rise: got %b want 1", offset, busy_a); end
    run_frame(0, nd, tmo);
    n_tests++; if (tmo !== 0) begin n_fail++; $display("FAIL full%0d_timeout: got %0d want 0", offset, tmo); end
    n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL full%0d_done_count: got %0d want 1", offset, nd); end
    n_tests++; if (q_a.size() !== exp.size()) begin n_fail++; $display("FAIL full%0d_len: got %0d want %0d", offset, q_a.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_tests++;
      if (i >= q_a.size() || q_a[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL full%0d_byte[%0d]: got %h want %h", offset, i, (i < q_a.size()) ? q_a[i] : 8'hxx, exp[i]);
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_decimation;
    logic [7:0] exp[$];
    logic [3:0] exp_addr[$];
    int nd, tmo;
    for (int i = 0; i < 16; i++) mem_a[i] = 8'(i);
    exp      = {8'hA5, 8'h5A, 8'h00, 8'h02, 8'h08, 8'h0A, 8'h00};
    exp_addr = {4'd0, 4'd2, 4'd8, 4'd10};
    q_a.delete();
    fetch_addr_a.delete();
    pulse_start_a(1'b1);
    run_frame(0, nd, tmo);
    n_tests++; if (tmo !== 0) begin n_fail++; $display("FAIL decim_timeout: got %0d want 0", tmo); end
    n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL decim_done_count: got %0d want 1", nd); end
    n_tests++; if (q_a.size() !== exp.size()) begin n_fail++; $display("FAIL decim_len: got %0d want %0d", q_a.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_tests++;
      if (i >= q_a.size() || q_a[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL decim_byte[%0d]: got %h want %h", i, (i < q_a.size()) ? q_a[i] : 8'hxx, exp[i]);
      end
    end
    n_tests++; if (fetch_addr_a.size() !== exp_addr.size()) begin n_fail++; $display("FAIL decim_naddr: got %0d want %0d", fetch_addr_a.size(), exp_addr.size()); end
    for (int i = 0; i < exp_addr.size(); i++) begin
      n_tests++;
      if (i >= fetch_addr_a.size() || fetch_addr_a[i] !== exp_addr[i]) begin
        n_fail++;
        $display("FAIL decim_addr[%0d]: got %0d want %0d", i, (i < fetch_addr_a.size()) ? fetch_addr_a[i] : 4'hx, exp_addr[i]);
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_multibyte;
    logic [7:0] exp[$];
    int nd, tmo;
    for (int i = 0; i < 16; i++) mem_b[i] = {8'(i), ~8'(i)};
    exp.delete();
    for (int i = 0; i < 16; i++) begin
      exp.push_back(8'(i));
      exp.push_back(~8'(i));
    end
    q_b.delete();
    fetch_len_b.delete();
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    run_frame(1, nd, tmo);
    n_tests++; if (tmo !== 0) begin n_fail++; $display("FAIL mb_timeout: got %0d want 0", tmo); end
    n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL mb_done_count: got %0d want 1", nd); end
    n_tests++; if (q_b.size() !== 32) begin n_fail++; $display("FAIL mb_len: got %0d want 32", q_b.size()); end
    for (int i = 0; i < 32; i++) begin
      n_tests++;
      if (i >= q_b.size() || q_b[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL mb_byte[%0d]: got %h want %h", i, (i < q_b.size()) ? q_b[i] : 8'hxx, exp[i]);
      end
    end
    // Capture on the 3rd cycle after the address change: FETCH lasts 4 cycles
    n_tests++; if (fetch_len_b.size() !== 16) begin n_fail++; $display("FAIL mb_nfetch: got %0d want 16", fetch_len_b.size()); end
    for (int i = 0; i < fetch_len_b.size(); i++) begin
      n_tests++;
      if (fetch_len_b[i] !== 4) begin n_fail++; $display("FAIL mb_fetch_len[%0d]: got %0d want 4", i, fetch_len_b[i]); end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_abort;
    logic [7:0] exp[$];
    int nd, tmo, qn;
    logic seen;
    for (int i = 0; i < 16; i++) mem_a[i] = 8'(i);
    exp = {8'hA5, 8'h5A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    q_a.delete();
    pulse_start_a(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (stb_a === 1'b1 && addr_a === 4'd5) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL abort_reach_addr5: got %b want 1", seen); end
    abort_a = 1'b1;
    run_frame(0, nd, tmo);
    n_tests++; if (tmo !== 0) begin n_fail++; $display("FAIL abort_timeout: got %0d want 0", tmo); end
    n_tests++; if (nd !== 0) begin n_fail++; $display("FAIL abort_done_count: got %0d want 0", nd); end
    repeat (200) @(negedge clk);
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy_a); end
    n_tests++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL abort_tx_idle: got %b want 1", tx_a); end
    qn = q_a.size();
    n_tests++; if (qn !== 8) begin n_fail++; $display("FAIL abort_len: got %0d want 8", qn); end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (i >= q_a.size() || q_a[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL abort_byte[%0d]: got %h want %h", i, (i < q_a.size()) ? q_a[i] : 8'hxx, exp[i]);
      end
    end
    abort_a = 1'b0;
    // A fresh frame afterwards starts again from the header
    test_full_frame(0, 8'h00);
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] exp[$];
    int nd, tmo;
    logic seen;
    for (int i = 0; i < 16; i++) mem_a[i] = 8'(i);
    exp = {8'hA5, 8'h5A};
    for (int i = 0; i < 16; i++) exp.push_back(8'(i));
    exp.push_back(8'h00);
    q_a.delete();
    pulse_start_a(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (addr_a === 4'd7) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_addr7: got %b want 1", seen); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (addr_a !== 4'd0) begin n_fail++; $display("FAIL rstmid_addr: got %h want 0", addr_a); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy_a); end
    n_tests++; if (state_a !== 3'd0) begin n_fail++; $display("FAIL rstmid_state: got %0d want 0", state_a); end
    n_tests++; if (byte_a !== 8'h00) begin n_fail++; $display("FAIL rstmid_byte: got %h want 00", byte_a); end
    n_tests++; if (stb_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_stb: got %b want 0", stb_a); end
    n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", done_a); end
    @(negedge clk);
    rst_n = 1'b1;
    // let any byte already on the line finish, then discard it
    repeat (60) @(negedge clk);
    q_a.delete();
    pulse_start_a(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (state_a === 3'd3) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_send: got %b want 1", seen); end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    run_frame(0, nd, tmo);
    n_tests++; if (tmo !== 0) begin n_fail++; $display("FAIL rstmid_timeout: got %0d want 0", tmo); end
    n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL rstmid_done_count: got %0d want 1", nd); end
    repeat (300) @(negedge clk);
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_second_frame: got busy %b want 0", busy_a); end
    n_tests++; if (q_a.size() !== exp.size()) begin n_fail++; $display("FAIL rstmid_len: got %0d want %0d", q_a.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_tests++;
      if (i >= q_a.size() || q_a[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL rstmid_byte[%0d]: got %h want %h", i, (i < q_a.size()) ? q_a[i] : 8'hxx, exp[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    test_reset;
    test_full_frame(0, 8'h00);
    test_full_frame(1, 8'h10);
    test_decimation;
    test_multibyte;
    test_abort;
    test_reset_mid_frame;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
